// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch sequencer: walks a synchronous ROM through
// fetch/load/decode/execute/update, computes the next PC and counts retired instructions.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 8,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instr,
  output logic               instr_valid,
  input  logic               decoder_done,
  input  logic               exec_done,
  input  logic               Branch,
  input  logic               Jump,
  input  logic               alu_zero,
  input  logic [3:0]         path_index,
  input  logic [25:0]        jump_address,
  input  logic [31:0]        imm_extended,
  input  logic [31:0]        jr_target,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               halted,
  output logic [15:0]        retired
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] DECODE = 3'd3;
  localparam logic [2:0] EXEC   = 3'd4;
  localparam logic [2:0] UPDATE = 3'd5;
  localparam logic [2:0] HALT   = 3'd6;

  logic [2:0]  state_reg;
  logic [31:0] pc_reg;
  logic [31:0] npc_reg;
  logic [31:0] npc_next;
  logic [31:0] instr_reg;
  logic [15:0] retired_reg;
  logic        dec_second_reg;

  assign pc          = pc_reg;
  assign pc_plus4    = pc_reg + 32'd4;
  assign imem_addr   = pc_reg[IMEM_AW+1:2];
  assign instr       = instr_reg;
  assign instr_valid = (state_reg == DECODE);
  assign halted      = (state_reg == HALT);
  assign retired     = retired_reg;

  // Next-PC select, priority jr > jump > taken branch > sequential.
  always_comb begin
    npc_next = pc_plus4;
    if (path_index == 4'b1000)
      npc_next = jr_target;
    else if (Jump)
      npc_next = {pc_plus4[31:28], jump_address, 2'b00};
    else if (Branch && alu_zero)
      npc_next = pc_plus4 + (imm_extended << 2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      npc_reg        <= RESET_PC;
      instr_reg      <= 32'd0;
      retired_reg    <= 16'd0;
      dec_second_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (start) state_reg <= FETCH;
        FETCH: state_reg <= LOAD;
        LOAD: begin
          instr_reg      <= imem_rdata;
          dec_second_reg <= 1'b0;
          state_reg      <= (imem_rdata[31:26] == HALT_OP) ? HALT : DECODE;
        end
        DECODE: begin
          // decoder_done in the first decode cycle may be stale from the previous instruction
          dec_second_reg <= 1'b1;
          if (dec_second_reg && decoder_done) state_reg <= EXEC;
        end
        EXEC: begin
          if (exec_done) begin
            npc_reg   <= npc_next;
            state_reg <= UPDATE;
          end
        end
        UPDATE: begin
          pc_reg      <= npc_reg;
          retired_reg <= retired_reg + 16'd1;
          state_reg   <= FETCH;
        end
        HALT: state_reg <= HALT;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
